instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding memory requester with output register and one-entry skid buffer.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_o and a sticky ERR state for unaligned redirect targets.
module instr_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] ERR  = 2'd3;
`endif

    localparam logic [DATA_WIDTH-1:0] FOUR       = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
    logic                  drop_q, drop_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0] out_pc4_q, out_pc4_d;

    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;

    logic                  in_err;
    logic                  redir_any;
    logic                  redir_bad;
    logic                  redir_take;
    logic                  consume;
    logic                  resp_take;
    logic [DATA_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign in_err    = (state_q == ERR);
    assign redir_bad = redirect_i && !in_err && (redirect_pc_i[1:0] != 2'b00);
    assign target    = redirect_pc_i;
`else
    assign in_err    = 1'b0;
    assign redir_bad = 1'b0;
    assign target    = redirect_pc_i & ALIGN_MASK;
`endif

    // A redirect flushes buffered words even when it is the misaligned kind.
    assign redir_any  = redirect_i && !in_err;
    assign redir_take = redir_any && !redir_bad;
    assign consume    = out_valid_q && !stall_i;
    assign resp_take  = (state_q == WAIT) && imem_rvalid_i && !drop_q && !redir_any;

    // Output register / skid buffer routing.
    always_comb begin
        // NOTE: every variable gets a default first so this block can never infer a latch.
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redir_any) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    out_pc4_d    = skid_pc_q + FOUR;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // After the consume step, an empty output register takes the response.
            if (resp_take) begin
                if (!out_valid_d) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata_i;
                    out_pc_d    = fpc_q;
                    out_pc4_d   = fpc_q + FOUR;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_rdata_i;
                    skid_pc_d    = fpc_q;
                end
            end
        end
    end

    // Fetch PC, drop flag and request FSM.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        drop_d  = drop_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif

        if (redir_take) begin
            fpc_d = target;
        end else if (resp_take) begin
            fpc_d = fpc_q + FOUR;
        end

        case (state_q)
            IDLE: begin
                if (!skid_valid_d) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    state_d = WAIT;
                    drop_d  = redir_take;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    drop_d = 1'b0;
                    if (resp_take && skid_valid_d) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end else if (redir_take) begin
                    drop_d = 1'b1;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            ERR:     state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase

`ifdef FETCH_MISALIGN_CHECK_EN
        if (redir_bad) begin
            state_d    = ERR;
            drop_d     = 1'b0;
            misalign_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            fpc_q        <= RESET_PC;
            drop_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_pc4_q    <= '0;
            // NOTE: skid storage is reset too, so no X can ever be routed onto instr_o.
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            drop_q       <= drop_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign imem_req_o    = (state_q == REQ);
    assign imem_addr_o   = fpc_q;
    assign instr_valid_o = out_valid_q;
    assign instr_o       = out_instr_q;
    assign pc_o          = out_pc_q;
    assign pc_plus4_o    = out_pc4_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_o    = misalign_q;
`endif

endmodule
